truth_table_sequencer: RTL and testbench

//  Sequences a combinational boolean-function unit (e.g. the two-output fxy block) through

---
 rtl/truth_table_sequencer.sv | 161 ++++++++++++++++
 tb/tb_truth_table_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer
//   Walks a combinational boolean-function unit through every input combination,
//   holds each vector for SETTLE+1 cycles, samples the unit's outputs for one cycle
//   and compares them against an expected table. Restartable; abortable.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a sweep (acted on in IDLE or DONE only)
//   abort      in   cancel a sweep / return to IDLE (priority over start)
//   exp_tbl    in   expected outputs, vector k at [N_OUT*k +: N_OUT]
//   dut_out    in   outputs of the unit under sweep, sampled in SAMPLE
//   vec        out  vector driven to the unit (MSB = first input)
//   busy       out  high in APPLY or SAMPLE
//   done       out  high in DONE
//   pass       out  high in DONE when no vector mismatched
//   err_count  out  mismatching vectors in the current or last sweep
//   first_err  out  index of the first mismatching vector (valid when err_count != 0)
//   cap_tbl    out  captured outputs, same layout as exp_tbl
module truth_table_sequencer #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned N_OUT  = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [N_OUT*(2**N_IN)-1:0]   exp_tbl,
  input  logic [N_OUT-1:0]             dut_out,
  output logic [N_IN-1:0]              vec,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [N_IN:0]                err_count,
  output logic [N_IN-1:0]              first_err,
  output logic [N_OUT*(2**N_IN)-1:0]   cap_tbl
);

  localparam int unsigned NVec = 2 ** N_IN;
  localparam int unsigned TblW = N_OUT * NVec;
  localparam int unsigned IdxW = $clog2(TblW);
  localparam int unsigned CntW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [N_IN-1:0] VecOne  = N_IN'(1);
  localparam logic [N_IN-1:0] VecLast = {N_IN{1'b1}};
  localparam logic [N_IN:0]   ErrOne  = (N_IN + 1)'(1);

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StSample,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [N_IN:0]     err_q, err_d;
  logic [N_IN-1:0]   first_q, first_d;
  logic [TblW-1:0]   cap_q, cap_d;

  logic [IdxW-1:0]   slice_base;
  logic [N_OUT-1:0]  exp_slice;
  logic              mismatch;

  // Slice of the tables belonging to the vector currently applied.
  always_comb begin
    slice_base = IdxW'(N_OUT * vec_q);
    exp_slice  = exp_tbl[slice_base +: N_OUT];
    mismatch   = (dut_out != exp_slice);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    err_d   = err_q;
    first_d = first_q;
    cap_d   = cap_q;

    case (state_q)
      StIdle, StDone: begin
        if (abort) begin
          state_d = StIdle;
        end else if (start) begin
          // cap_tbl is deliberately kept; it is overwritten vector by vector.
          state_d = StApply;
          cnt_d   = '0;
          vec_d   = '0;
          err_d   = '0;
          first_d = '0;
        end
      end

      StApply: begin
        if (abort) begin
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StSample: begin
        if (abort) begin
          // Capture of this vector is dropped; partial results remain visible.
          state_d = StIdle;
        end else begin
          cap_d[slice_base +: N_OUT] = dut_out;
          if (mismatch) begin
            err_d = err_q + ErrOne;
            if (err_q == '0) begin
              first_d = vec_q;
            end
          end
          if (vec_q == VecLast) begin
            state_d = StDone;
          end else begin
            state_d = StApply;
            vec_d   = vec_q + VecOne;
            cnt_d   = '0;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      first_q <= first_d;
      cap_q   <= cap_d;
    end
  end

  // Outputs come from registers or state decode only; dut_out never reaches them directly.
  assign vec       = vec_q;
  assign busy      = (state_q == StApply) || (state_q == StSample);
  assign done      = (state_q == StDone);
  assign pass      = (state_q == StDone) && (err_q == '0);
  assign err_count = err_q;
  assign first_err = first_q;
  assign cap_tbl   = cap_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer. Three instances: default SETTLE=1 (main),
// SETTLE=0 and SETTLE=3. The swept unit is a two-output NAND-like fxy block:
// {x,y} = 00,01,10 -> {s1,s2} = 11 ; 11 -> 00, i.e. expected table 8'h3F.
module tb_truth_table_sequencer;

  logic clk;
  logic rst_n;

  // Main instance (SETTLE = 1)
  logic       start, abort, force_zero;
  logic [7:0] exp_tbl;
  logic [1:0] dut_out;
  logic [1:0] vec;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [1:0] first_err;
  logic [7:0] cap_tbl;

  // SETTLE = 0 and SETTLE = 3 instances
  logic       start_b;
  logic [1:0] dut_out_s0, dut_out_s3;
  logic [1:0] vec_s0, vec_s3;
  logic       busy_s0, busy_s3, done_s0, done_s3, pass_s0, pass_s3;
  logic [2:0] err_s0, err_s3;
  logic [1:0] first_s0, first_s3;
  logic [7:0] cap_s0, cap_s3;

  int n_checks;
  int n_errors;

  function automatic logic [1:0] fxy(input logic [1:0] v);
    return (v == 2'b11) ? 2'b00 : 2'b11;
  endfunction

  assign dut_out    = force_zero ? 2'b00 : fxy(vec);
  assign dut_out_s0 = fxy(vec_s0);
  assign dut_out_s3 = fxy(vec_s3);

  truth_table_sequencer #(.N_IN(2), .N_OUT(2), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .exp_tbl(exp_tbl),
    .dut_out(dut_out), .vec(vec), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err(first_err), .cap_tbl(cap_tbl)
  );

  truth_table_sequencer #(.N_IN(2), .N_OUT(2), .SETTLE(0)) u_dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0), .exp_tbl(8'h3F),
    .dut_out(dut_out_s0), .vec(vec_s0), .busy(busy_s0), .done(done_s0), .pass(pass_s0),
    .err_count(err_s0), .first_err(first_s0), .cap_tbl(cap_s0)
  );

  truth_table_sequencer #(.N_IN(2), .N_OUT(2), .SETTLE(3)) u_dut_s3 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0), .exp_tbl(8'h3F),
    .dut_out(dut_out_s3), .vec(vec_s3), .busy(busy_s3), .done(done_s3), .pass(pass_s3),
    .err_count(err_s3), .first_err(first_s3), .cap_tbl(cap_s3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulses start on the main instance from a negedge; returns the cycles from the
  // start-sampling edge to the edge entering DONE (-1 on timeout). restart_at != 0
  // pulses start again mid-sweep at that cycle.
  task automatic run_sweep(input int restart_at, output int lat);
    lat   = -1;
    start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = (restart_at != 0) && (n == restart_at);
      if (done) begin
        lat = n - 1;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int lat;
    int lat0, lat3, hold0, hold3;
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    start_b    = 1'b0;
    abort      = 1'b0;
    force_zero = 1'b0;
    exp_tbl    = 8'h3F;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check_eq("rst_vec", 32'(vec), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    check_eq("rst_pass", 32'(pass), 32'h0);
    check_eq("rst_err", 32'(err_count), 32'h0);
    check_eq("rst_cap", 32'(cap_tbl), 32'h0);

    // 1: clean sweep
    run_sweep(0, lat);
    check_eq("t1_lat", 32'(lat), 32'd12);
    check_eq("t1_pass", 32'(pass), 32'h1);
    check_eq("t1_busy", 32'(busy), 32'h0);
    check_eq("t1_err", 32'(err_count), 32'h0);
    check_eq("t1_cap", 32'(cap_tbl), 32'h3F);
    check_eq("t1_vec", 32'(vec), 32'h3);

    // 2: vector 0 expects 00, restarted from DONE
    exp_tbl = 8'h3C;
    run_sweep(0, lat);
    check_eq("t2_lat", 32'(lat), 32'd12);
    check_eq("t2_pass", 32'(pass), 32'h0);
    check_eq("t2_err", 32'(err_count), 32'h1);
    check_eq("t2_first", 32'(first_err), 32'h0);
    check_eq("t2_cap", 32'(cap_tbl), 32'h3F);

    // 3: every vector mismatches
    force_zero = 1'b1;
    exp_tbl    = 8'hFF;
    run_sweep(0, lat);
    check_eq("t3_err", 32'(err_count), 32'h4);
    check_eq("t3_first", 32'(first_err), 32'h0);
    check_eq("t3_pass", 32'(pass), 32'h0);
    check_eq("t3_cap", 32'(cap_tbl), 32'h00);

    // 4: abort when vec reaches 2
    force_zero = 1'b0;
    exp_tbl    = 8'h3F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 20 && vec != 2'd2; n++) @(negedge clk);
    check_eq("t4_vec2", 32'(vec), 32'h2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("t4_busy", 32'(busy), 32'h0);
    check_eq("t4_done", 32'(done), 32'h0);
    check_eq("t4_cap", 32'(cap_tbl), 32'h0F);
    check_eq("t4_err", 32'(err_count), 32'h0);
    run_sweep(0, lat);
    check_eq("t4_lat", 32'(lat), 32'd12);
    check_eq("t4_pass", 32'(pass), 32'h1);
    check_eq("t4_cap2", 32'(cap_tbl), 32'h3F);

    // 5: start while busy is ignored, then async reset mid-APPLY
    run_sweep(5, lat);
    check_eq("t5_lat", 32'(lat), 32'd12);
    check_eq("t5_pass", 32'(pass), 32'h1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 20 && vec != 2'd1; n++) @(negedge clk);
    check_eq("t5_vec1", 32'(vec), 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rvec", 32'(vec), 32'h0);
    check_eq("t5_rbusy", 32'(busy), 32'h0);
    check_eq("t5_rdone", 32'(done), 32'h0);
    check_eq("t5_rcap", 32'(cap_tbl), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 6: SETTLE = 0 and SETTLE = 3 sweeps
    lat0    = -1;
    lat3    = -1;
    hold0   = 0;
    hold3   = 0;
    start_b = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (vec_s0 == 2'd1) hold0++;
      if (vec_s3 == 2'd1) hold3++;
      if (done_s0 && lat0 < 0) lat0 = n - 1;
      if (done_s3 && lat3 < 0) lat3 = n - 1;
      if (lat0 >= 0 && lat3 >= 0) break;
    end
    check_eq("t6_lat0", 32'(lat0), 32'd8);
    check_eq("t6_lat3", 32'(lat3), 32'd20);
    check_eq("t6_hold0", 32'(hold0), 32'd2);
    check_eq("t6_hold3", 32'(hold3), 32'd5);
    check_eq("t6_pass0", 32'(pass_s0), 32'h1);
    check_eq("t6_pass3", 32'(pass_s3), 32'h1);
    check_eq("t6_cap0", 32'(cap_s0), 32'h3F);
    check_eq("t6_cap3", 32'(cap_s3), 32'h3F);
    check_eq("t6_err0", 32'({err_s0, first_s0, busy_s0}), 32'h0);
    check_eq("t6_err3", 32'({err_s3, first_s3, busy_s3}), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
